// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer display sequencer.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } cd_state_t;

   typedef struct packed {
      logic [3:0] m_t;
      logic [3:0] m_o;
      logic [3:0] s_t;
      logic [3:0] s_o;
   } bcd_mmss_t;

   localparam bcd_mmss_t BCD_ZERO = 16'h0000;

   // Out-of-range preset digits saturate to the largest legal digit for their position
   function automatic bcd_mmss_t clamp_preset(input logic [15:0] raw);
      bcd_mmss_t c;
      c.m_t = (raw[15:12] > 4'd9) ? 4'd9 : raw[15:12];
      c.m_o = (raw[11:8]  > 4'd9) ? 4'd9 : raw[11:8];
      c.s_t = (raw[7:4]   > 4'd5) ? 4'd5 : raw[7:4];
      c.s_o = (raw[3:0]   > 4'd9) ? 4'd9 : raw[3:0];
      return c;
   endfunction

endpackage

// File: rtl/countdown_controller_if.sv
// Command and display bundle between the timer front panel and the countdown sequencer.
interface countdown_controller_if;

   logic        load;
   logic [15:0] preset;
   logic        start_pause;
   logic        clear;
   logic [3:0]  digit_3;
   logic [3:0]  digit_2;
   logic [3:0]  digit_1;
   logic [3:0]  digit_0;
   logic        enable_3;
   logic        enable_2;
   logic        enable_1;
   logic        enable_0;
   logic        running;
   logic        alarm;

   modport master (
      output load, preset, start_pause, clear,
      input  digit_3, digit_2, digit_1, digit_0,
      input  enable_3, enable_2, enable_1, enable_0,
      input  running, alarm
   );

   modport slave (
      input  load, preset, start_pause, clear,
      output digit_3, digit_2, digit_1, digit_0,
      output enable_3, enable_2, enable_1, enable_0,
      output running, alarm
   );

endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a BCD mm:ss value, flagging when the result hits 00:00.
module bcd_mmss_dec
   import countdown_pkg::*;
(
   input  bcd_mmss_t count,
   output bcd_mmss_t dec_out,
   output logic      is_zero
);

   // Borrow ripples s_o -> s_t -> m_o -> m_t; seconds tens wrap at 5, all others at 9
   always_comb begin
      dec_out = count;
      if (count.s_o != 4'd0) begin
         dec_out.s_o = count.s_o - 4'd1;
      end else begin
         dec_out.s_o = 4'd9;
         if (count.s_t != 4'd0) begin
            dec_out.s_t = count.s_t - 4'd1;
         end else begin
            dec_out.s_t = 4'd5;
            if (count.m_o != 4'd0) begin
               dec_out.m_o = count.m_o - 4'd1;
            end else begin
               dec_out.m_o = 4'd9;
               dec_out.m_t = count.m_t - 4'd1;
            end
         end
      end
      is_zero = (dec_out == BCD_ZERO);
   end

endmodule

// File: rtl/countdown_controller.sv
// Countdown timer sequencer: mm:ss count, IDLE/RUN/PAUSE/DONE control and display enables.
// Outputs are registered from the next-state values so commands show up right after their edge.
module countdown_controller
   import countdown_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int BLINK_CYCLES  = 500
) (
   input logic                   clk,
   input logic                   rst_n,
   countdown_controller_if.slave bus
);

   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_CYCLES - 1);

   cd_state_t        state;
   cd_state_t        next_state;
   bcd_mmss_t        count;
   bcd_mmss_t        next_count;
   bcd_mmss_t        dec_count;
   logic             dec_is_zero;
   logic [PRE_W-1:0] prescaler;
   logic [PRE_W-1:0] next_prescaler;
   logic [BLK_W-1:0] blink_cnt;
   logic [BLK_W-1:0] next_blink_cnt;
   logic             blink_phase;
   logic             next_blink_phase;
   logic             tick;
   logic             enable_3_q;
   logic             enable_3_d;
   logic [2:0]       enable_lo_q;
   logic [2:0]       enable_lo_d;
   logic             running_q;
   logic             running_d;
   logic             alarm_q;
   logic             alarm_d;

   bcd_mmss_dec u_dec (
      .count   (count),
      .dec_out (dec_count),
      .is_zero (dec_is_zero)
   );

   assign tick = (prescaler == PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= BCD_ZERO;
         prescaler   <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         enable_3_q  <= 1'b0;
         enable_lo_q <= 3'b111;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state       <= next_state;
         count       <= next_count;
         prescaler   <= next_prescaler;
         blink_cnt   <= next_blink_cnt;
         blink_phase <= next_blink_phase;
         enable_3_q  <= enable_3_d;
         enable_lo_q <= enable_lo_d;
         running_q   <= running_d;
         alarm_q     <= alarm_d;
      end
   end

   // Command priority is clear > load > start_pause; expiry beats a coincident pause
   always_comb begin
      next_state       = state;
      next_count       = count;
      next_prescaler   = prescaler;
      next_blink_cnt   = '0;
      next_blink_phase = blink_phase;
      case (state)
         ST_IDLE: begin
            if (bus.clear) begin
               next_count = BCD_ZERO;
            end else if (bus.load) begin
               next_count = clamp_preset(bus.preset);
            end else if (bus.start_pause && (count != BCD_ZERO)) begin
               next_state     = ST_RUN;
               next_prescaler = '0;
            end
         end
         ST_RUN: begin
            next_prescaler = tick ? '0 : prescaler + 1'b1;
            if (bus.clear) begin
               next_state = ST_IDLE;
               next_count = BCD_ZERO;
            end else begin
               if (tick) begin
                  next_count = dec_count;
               end
               if (tick && dec_is_zero) begin
                  next_state       = ST_DONE;
                  next_blink_phase = 1'b1;
               end else if (bus.start_pause) begin
                  next_state = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (bus.clear) begin
               next_state = ST_IDLE;
               next_count = BCD_ZERO;
            end else if (bus.load) begin
               next_state = ST_IDLE;
               next_count = clamp_preset(bus.preset);
            end else if (bus.start_pause) begin
               next_state = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.clear || (bus.start_pause && !bus.load)) begin
               next_state = ST_IDLE;
               next_count = BCD_ZERO;
            end else if (bus.load) begin
               next_state = ST_IDLE;
               next_count = clamp_preset(bus.preset);
            end else if (blink_cnt == BLK_MAX) begin
               next_blink_phase = ~blink_phase;
            end else begin
               next_blink_cnt = blink_cnt + 1'b1;
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_count = BCD_ZERO;
         end
      endcase
   end

   // Leading minute-tens blanking while counting; every digit blinks together once expired
   always_comb begin
      running_d = (next_state == ST_RUN);
      alarm_d   = (next_state == ST_DONE);
      if (next_state == ST_DONE) begin
         enable_3_d  = next_blink_phase;
         enable_lo_d = {3{next_blink_phase}};
      end else begin
         enable_3_d  = (next_count.m_t != 4'd0);
         enable_lo_d = 3'b111;
      end
   end

   assign bus.digit_3  = count.m_t;
   assign bus.digit_2  = count.m_o;
   assign bus.digit_1  = count.s_t;
   assign bus.digit_0  = count.s_o;
   assign bus.enable_3 = enable_3_q;
   assign bus.enable_2 = enable_lo_q[2];
   assign bus.enable_1 = enable_lo_q[1];
   assign bus.enable_0 = enable_lo_q[0];
   assign bus.running  = running_q;
   assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Bench for countdown_controller: a seconds-based reference model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized command traffic.
module tb_countdown_controller;

   localparam int TICKS = 4;
   localparam int BLINK = 2;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   check_en     = 1'b0;

   int m_state;
   int m_secs;
   int m_run_cycles;
   int m_done_cycles;

   logic [15:0] dut_digits;
   logic [3:0]  dut_enables;

   countdown_controller_if bus ();

   countdown_controller #(
      .TICKS_PER_SEC (TICKS),
      .BLINK_CYCLES  (BLINK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign dut_digits  = {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0};
   assign dut_enables = {bus.enable_3, bus.enable_2, bus.enable_1, bus.enable_0};

   always #5 clk = ~clk;

   // The model keeps the remaining time as plain seconds and derives digits arithmetically
   function automatic int clampSecs(input logic [15:0] p);
      int mt, mo, st, so;
      mt = (int'(p[15:12]) > 9) ? 9 : int'(p[15:12]);
      mo = (int'(p[11:8])  > 9) ? 9 : int'(p[11:8]);
      st = (int'(p[7:4])   > 5) ? 5 : int'(p[7:4]);
      so = (int'(p[3:0])   > 9) ? 9 : int'(p[3:0]);
      return (mt * 10 + mo) * 60 + st * 10 + so;
   endfunction

   function automatic logic [15:0] expDigits();
      int mm, ss;
      mm = m_secs / 60;
      ss = m_secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [3:0] expEnables();
      if (m_state == M_DONE)
         return (((m_done_cycles / BLINK) % 2) == 0) ? 4'b1111 : 4'b0000;
      return (m_secs >= 600) ? 4'b1111 : 4'b0111;
   endfunction

   task automatic modelReset();
      m_state       = M_IDLE;
      m_secs        = 0;
      m_run_cycles  = 0;
      m_done_cycles = 0;
   endtask

   task automatic modelStep(input bit ld, input logic [15:0] pre, input bit sp, input bit clr);
      bit tick;
      case (m_state)
         M_IDLE: begin
            if (clr) m_secs = 0;
            else if (ld) m_secs = clampSecs(pre);
            else if (sp && m_secs != 0) begin
               m_state      = M_RUN;
               m_run_cycles = 0;
            end
         end
         M_RUN: begin
            m_run_cycles++;
            tick = ((m_run_cycles % TICKS) == 0);
            if (clr) begin
               m_state = M_IDLE;
               m_secs  = 0;
            end else begin
               if (tick) m_secs--;
               if (tick && m_secs == 0) begin
                  m_state       = M_DONE;
                  m_done_cycles = 0;
               end else if (sp) begin
                  m_state = M_PAUSE;
               end
            end
         end
         M_PAUSE: begin
            if (clr) begin
               m_state = M_IDLE;
               m_secs  = 0;
            end else if (ld) begin
               m_state = M_IDLE;
               m_secs  = clampSecs(pre);
            end else if (sp) begin
               m_state = M_RUN;
            end
         end
         default: begin
            if (clr) begin
               m_state = M_IDLE;
               m_secs  = 0;
            end else if (ld) begin
               m_state = M_IDLE;
               m_secs  = clampSecs(pre);
            end else if (sp) begin
               m_state = M_IDLE;
               m_secs  = 0;
            end else begin
               m_done_cycles++;
            end
         end
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit ld, input logic [15:0] pre, input bit sp, input bit clr);
      bus.load        = ld;
      bus.preset      = pre;
      bus.start_pause = sp;
      bus.clear       = clr;
      @(posedge clk);
      modelStep(ld, pre, sp, clr);
      #2;
      bus.load        = 1'b0;
      bus.start_pause = 1'b0;
      bus.clear       = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // Checks that reset forces its values immediately, with no clock edge in between
   task automatic asyncResetCheck(input string tag);
      #1 rst_n = 1'b0;
      #1;
      checkOutput({tag, "_rst_digits"},  dut_digits, 16'h0000);
      checkOutput({tag, "_rst_enables"}, {12'h000, dut_enables}, 16'h0007);
      checkOutput({tag, "_rst_running"}, {15'h0000, bus.running}, 16'h0000);
      checkOutput({tag, "_rst_alarm"},   {15'h0000, bus.alarm}, 16'h0000);
      modelReset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      idleCycles(1);
   endtask

   always @(negedge clk) begin
      if (rst_n && check_en) begin
         checkOutput("cyc_digits",  dut_digits, expDigits());
         checkOutput("cyc_enables", {12'h000, dut_enables}, {12'h000, expEnables()});
         checkOutput("cyc_running", {15'h0000, bus.running}, {15'h0000, (m_state == M_RUN)});
         checkOutput("cyc_alarm",   {15'h0000, bus.alarm}, {15'h0000, (m_state == M_DONE)});
      end
   end

   initial begin
      bus.load        = 1'b0;
      bus.preset      = 16'h0000;
      bus.start_pause = 1'b0;
      bus.clear       = 1'b0;
      modelReset();

      // Reset pulse and ignored start at 00:00
      repeat (3) @(negedge clk);
      checkOutput("reset_digits",  dut_digits, 16'h0000);
      checkOutput("reset_enables", {12'h000, dut_enables}, 16'h0007);
      checkOutput("reset_running", {15'h0000, bus.running}, 16'h0000);
      checkOutput("reset_alarm",   {15'h0000, bus.alarm}, 16'h0000);
      #2 rst_n = 1'b1;
      check_en = 1'b1;
      idleCycles(1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("s1_running", {15'h0000, bus.running}, 16'h0000);
      idleCycles(2);
      checkOutput("s1_running_later", {15'h0000, bus.running}, 16'h0000);

      // 01:02 counting down across the minute boundary
      applyStimulus(1'b1, 16'h0102, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("s2_running", {15'h0000, bus.running}, 16'h0001);
      idleCycles(4);
      checkOutput("s2_digits_4", dut_digits, 16'h0101);
      checkOutput("s2_model_4", expDigits(), 16'h0101);
      idleCycles(4);
      checkOutput("s2_digits_8", dut_digits, 16'h0100);
      idleCycles(4);
      checkOutput("s2_digits_12", dut_digits, 16'h0059);
      checkOutput("s2_model_12", expDigits(), 16'h0059);
      asyncResetCheck("s2_run");

      // Expiry, blink pattern and acknowledge
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      idleCycles(4);
      checkOutput("s3_alarm",   {15'h0000, bus.alarm}, 16'h0001);
      checkOutput("s3_running", {15'h0000, bus.running}, 16'h0000);
      checkOutput("s3_digits",  dut_digits, 16'h0000);
      checkOutput("s3_en_0", {12'h000, dut_enables}, 16'h000F);
      checkOutput("s3_model_en_0", {12'h000, expEnables()}, 16'h000F);
      idleCycles(1);
      checkOutput("s3_en_1", {12'h000, dut_enables}, 16'h000F);
      idleCycles(1);
      checkOutput("s3_en_2", {12'h000, dut_enables}, 16'h0000);
      checkOutput("s3_model_en_2", {12'h000, expEnables()}, 16'h0000);
      idleCycles(1);
      checkOutput("s3_en_3", {12'h000, dut_enables}, 16'h0000);
      idleCycles(1);
      checkOutput("s3_en_4", {12'h000, dut_enables}, 16'h000F);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("s3_ack_alarm", {15'h0000, bus.alarm}, 16'h0000);

      // Reset while blinking in DONE
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      idleCycles(7);
      asyncResetCheck("s3_done");

      // Pause freezes the count and the prescaler position
      applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         idleCycles(1);
         checkOutput("s4_frozen", dut_digits, 16'h0010);
      end
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("s4_resume_1", dut_digits, 16'h0010);
      idleCycles(1);
      checkOutput("s4_resume_2", dut_digits, 16'h0009);
      checkOutput("s4_model_2", expDigits(), 16'h0009);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

      // Clamping and leading-zero blanking
      applyStimulus(1'b1, 16'hAF7C, 1'b0, 1'b0);
      checkOutput("s5_clamp", dut_digits, 16'h9959);
      checkOutput("s5_model_clamp", expDigits(), 16'h9959);
      checkOutput("s5_en_full", {12'h000, dut_enables}, 16'h000F);
      applyStimulus(1'b1, 16'h0500, 1'b0, 1'b0);
      checkOutput("s5_en_blank", {12'h000, dut_enables}, 16'h0007);

      // Simultaneous commands while running: clear wins
      applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      idleCycles(2);
      applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1);
      checkOutput("s6_digits",  dut_digits, 16'h0000);
      checkOutput("s6_running", {15'h0000, bus.running}, 16'h0000);

      // Randomized traffic, biased toward short presets so expiry happens often
      for (int i = 0; i < 3000; i++) begin
         bit          ld, sp, clr;
         logic [15:0] pre;
         ld  = ($urandom_range(0, 15) == 0);
         sp  = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0)
            pre = 16'($urandom);
         else
            pre = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 12))};
         applyStimulus(ld, pre, sp, clr);
         if (i == 1500) asyncResetCheck("rand");
      end

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
